// File: rtl/pretrig_capture_buffer.sv
// Pre-trigger capture buffer: records every incoming sample into a circular RAM.
// A VAD trigger replays up to pre_len samples of history and then streams live
// samples. A gate_end drains only what was pending at that moment. When the RAM
// is full, the oldest unread sample is dropped and a sticky overrun flag is set.
module pretrig_capture_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 24000,
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic [ADDR_WIDTH-1:0] pre_len,
  input  logic                  trigger,
  input  logic                  gate_end,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] occupancy,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ONE     = ADDR_WIDTH'(1);

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr, hist_cnt, occ, rem;
  logic [ADDR_WIDTH-1:0] plen_c, pre_n, keep, preload, start_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr_nxt, occ_nxt, rem_nxt, pend;
  logic                  trig_acc, trig_drop, rd_issue, drop, drain_done, out_free;

  // Pointer increment with explicit wrap; DEPTH need not be a power of two.
  function automatic logic [ADDR_WIDTH-1:0] wrap_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == LAST) ? '0 : p + ONE;
  endfunction

  // Trigger preload: clamp the request to the recorded history. If the history
  // is full and a sample lands in the same cycle, one old sample is given up
  // so that the pending count never exceeds DEPTH-1.
  always_comb begin
    plen_c    = (pre_len > LAST) ? LAST : pre_len;
    pre_n     = (plen_c < hist_cnt) ? plen_c : hist_cnt;
    trig_drop = in_valid && (pre_n == LAST);
    keep      = trig_drop ? (LAST - ONE) : pre_n;
    preload   = keep + ADDR_WIDTH'(in_valid);
    start_ptr = (wr_ptr >= keep) ? (wr_ptr - keep) : (wr_ptr + (DEPTH_A - keep));
  end

  // Next-state logic plus read-issue, overflow-drop and count bookkeeping.
  always_comb begin
    state_nxt  = state;
    occ_nxt    = occ;
    rem_nxt    = rem;
    rd_ptr_nxt = rd_ptr;
    trig_acc   = (state == IDLE) && trigger;
    out_free   = !out_valid || out_ready;
    pend       = (state == DRAIN) ? rem : occ;
    rd_issue   = (state != IDLE) && (pend != '0) && out_free;
    drop       = in_valid && (state != IDLE) && (occ == LAST) && !rd_issue;
    drain_done = (state == DRAIN) && (rem == '0) && out_free;

    if (rd_issue || drop) rd_ptr_nxt = wrap_inc(rd_ptr);
    if (!drop) occ_nxt = occ + ADDR_WIDTH'(in_valid) - ADDR_WIDTH'(rd_issue);

    case (state)
      IDLE: begin
        occ_nxt = '0;
        rem_nxt = '0;
        if (trigger) begin
          rd_ptr_nxt = start_ptr;
          occ_nxt    = preload;
          if (gate_end) begin
            rem_nxt   = preload;
            state_nxt = DRAIN;
          end else begin
            state_nxt = STREAM;
          end
        end
      end
      STREAM: begin
        rem_nxt = '0;
        // Freeze the pending count: this cycle's write counts, this cycle's read does not.
        if (gate_end) begin
          rem_nxt   = occ_nxt;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        rem_nxt = rem - ADDR_WIDTH'(rd_issue) - ADDR_WIDTH'(drop && (rem != '0));
        if (drain_done) begin
          state_nxt = IDLE;
          occ_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Sample RAM: written every valid sample and never cleared.
  always_ff @(posedge clk) begin
    if (in_valid) mem[wr_ptr] <= in_data;
  end

  // Pointers, counters, output register and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      hist_cnt  <= '0;
      occ       <= '0;
      rem       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (in_valid) begin
        wr_ptr <= wrap_inc(wr_ptr);
        if (hist_cnt != LAST) hist_cnt <= hist_cnt + ONE;
      end
      rd_ptr    <= rd_ptr_nxt;
      occ       <= occ_nxt;
      rem       <= rem_nxt;
      if (rd_issue) out_data <= mem[rd_ptr];
      out_valid <= rd_issue || (out_valid && !out_ready);
      done      <= drain_done;
      if (trig_acc)  overrun <= trig_drop;
      else if (drop) overrun <= 1'b1;
    end
  end

  assign occupancy = occ;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_pretrig_capture_buffer.sv
// Bench for pretrig_capture_buffer (DEPTH=16). A queue-level reference model
// pushes expected output samples into a scoreboard, and a negedge monitor pops
// and compares them on every accepted output. The directed scenarios are
// followed by a randomized phase.
module tb_pretrig_capture_buffer;
  localparam int DW = 16;
  localparam int D  = 16;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic [AW-1:0] pre_len = '0;
  logic          trigger = 1'b0;
  logic          gate_end = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] occupancy;
  logic          busy, done, overrun;

  pretrig_capture_buffer #(.DATA_WIDTH(DW), .DEPTH(D), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .pre_len(pre_len), .trigger(trigger), .gate_end(gate_end),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .occupancy(occupancy), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  // Reference model: mode 0 idle, 1 stream, 2 drain.
  int          m_mode = 0;
  int          m_rem = 0;
  bit          m_ov = 0, m_done = 0, m_ovr = 0;
  logic [DW-1:0] hist[$], unread[$], exp_q[$], got_q[$], want_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit iv, input logic [DW-1:0] d,
                            input bit trg, input bit ge, input int pl, input bit rdy);
    int n;
    bit rd, ex;
    if (r) begin
      hist.delete(); unread.delete(); exp_q.delete();
      m_mode = 0; m_rem = 0; m_ov = 0; m_done = 0; m_ovr = 0;
      return;
    end
    m_done = 0;
    if (m_mode == 0) begin
      if (trg) begin
        n = pl;
        if (n > hist.size()) n = hist.size();
        if (n > D - 1) n = D - 1;
        unread.delete();
        for (int i = hist.size() - n; i < hist.size(); i++) unread.push_back(hist[i]);
        m_ovr = 0;
        if (iv) begin
          unread.push_back(d);
          if (unread.size() > D - 1) begin void'(unread.pop_front()); m_ovr = 1; end
        end
        m_mode = ge ? 2 : 1;
        m_rem  = ge ? unread.size() : 0;
      end
    end else begin
      rd = ((m_mode == 2) ? (m_rem > 0) : (unread.size() > 0)) && (!m_ov || rdy);
      ex = (m_mode == 2) && (m_rem == 0) && (!m_ov || rdy);
      if (rd) begin
        exp_q.push_back(unread.pop_front());
        if (m_mode == 2) m_rem--;
      end
      m_ov = rd || (m_ov && !rdy);
      if (iv) begin
        unread.push_back(d);
        if (unread.size() > D - 1) begin
          void'(unread.pop_front());
          m_ovr = 1;
          if (m_mode == 2 && m_rem > 0) m_rem--;
        end
      end
      if (m_mode == 1 && ge) begin
        m_mode = 2;
        m_rem  = unread.size();
      end else if (ex) begin
        m_mode = 0;
        unread.delete();
        m_done = 1;
      end
    end
    if (iv) begin
      hist.push_back(d);
      if (hist.size() > D - 1) void'(hist.pop_front());
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare status.
  task automatic cyc(input bit r, input bit iv, input logic [DW-1:0] d,
                     input bit trg, input bit ge, input int pl, input bit rdy);
    rst = r; in_valid = iv; in_data = d; trigger = trg; gate_end = ge;
    pre_len = AW'(pl); out_ready = rdy;
    @(posedge clk);
    #1;
    model_step(r, iv, d, trg, ge, pl % 32, rdy);
    chk("occupancy", 32'(occupancy), 32'(unread.size()));
    chk("busy",      32'(busy),      32'(m_mode != 0));
    chk("done",      32'(done),      32'(m_done));
    chk("overrun",   32'(overrun),   32'(m_ovr));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(0, 0, '0, 0, 0, 0, rdy);
  endtask

  task automatic wr(input int d, input bit rdy);
    cyc(0, 1, DW'(d), 0, 0, 0, rdy);
  endtask

  task automatic check_got(input string name);
    chk({name, "_count"}, 32'(got_q.size()), 32'(want_q.size()));
    for (int i = 0; i < want_q.size() && i < got_q.size(); i++)
      chk(name, 32'(got_q[i]), 32'(want_q[i]));
  endtask

  // Output monitor: every accepted sample must match the scoreboard head.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_data: got %0d expected no output (t=%0t)", out_data, $time);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(e));
      end
      got_q.push_back(out_data);
    end
    if (!rst && done) done_cnt++;
  end

  initial begin
    int rdy_bias;
    bit r, iv, trg, ge, rdy;

    // Reset and plain replay of the last four of ten samples.
    cyc(1, 0, '0, 0, 0, 0, 1);
    cyc(1, 0, '0, 0, 0, 0, 1);
    chk("reset_out_data", 32'(out_data), 32'd0);
    for (int k = 1; k <= 10; k++) wr(k, 1);
    got_q.delete();
    cyc(0, 0, '0, 1, 0, 4, 1);
    idle(6, 1);
    want_q = '{16'd7, 16'd8, 16'd9, 16'd10};
    check_got("t1_replay");
    chk("t1_still_stream", 32'(busy), 32'd1);
    cyc(0, 0, '0, 0, 1, 0, 1);
    idle(3, 1);

    // History shorter than pre_len.
    cyc(1, 0, '0, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) wr(100 + k, 1);
    got_q.delete();
    cyc(0, 0, '0, 1, 0, 8, 1);
    idle(5, 1);
    want_q = '{16'd100, 16'd101, 16'd102};
    check_got("t2_hist_clamp");
    chk("t2_overrun", 32'(overrun), 32'd0);
    cyc(0, 0, '0, 0, 1, 0, 1);
    idle(3, 1);

    // Overflow while stalled: the head sample stays in the output register, 201..204 are dropped.
    cyc(1, 0, '0, 0, 0, 0, 1);
    cyc(0, 0, '0, 1, 0, 0, 1);
    got_q.delete();
    for (int k = 0; k < 20; k++) wr(200 + k, 0);
    chk("t3_occ_sat", 32'(occupancy), 32'd15);
    chk("t3_overrun", 32'(overrun), 32'd1);
    idle(18, 1);
    want_q.delete();
    want_q.push_back(16'd200);
    for (int k = 205; k < 220; k++) want_q.push_back(DW'(k));
    check_got("t3_after_drop");

    // Drain only what was pending at gate_end; later writes are not emitted.
    got_q.delete();
    done_cnt = 0;
    for (int k = 0; k < 5; k++) wr(300 + k, 0);
    cyc(0, 0, '0, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) wr(305 + k, 0);
    idle(10, 1);
    want_q = '{16'd300, 16'd301, 16'd302, 16'd303, 16'd304};
    check_got("t4_drain");
    chk("t4_done_pulses", 32'(done_cnt), 32'd1);
    chk("t4_idle", 32'(busy), 32'd0);

    // trigger+gate_end together, then a trigger ignored while streaming.
    got_q.delete();
    done_cnt = 0;
    cyc(0, 0, '0, 1, 1, 2, 1);
    idle(6, 1);
    want_q = '{16'd306, 16'd307};
    check_got("t5_trig_gate");
    chk("t5_done_pulses", 32'(done_cnt), 32'd1);
    got_q.delete();
    cyc(0, 0, '0, 1, 0, 2, 1);
    idle(3, 1);
    wr(400, 1);
    wr(401, 1);
    cyc(0, 1, 16'd402, 1, 0, 10, 1);
    wr(403, 1);
    idle(4, 1);
    want_q = '{16'd306, 16'd307, 16'd400, 16'd401, 16'd402, 16'd403};
    check_got("t5_ignored_trigger");
    cyc(0, 0, '0, 0, 1, 0, 1);
    idle(3, 1);

    // Reset in the middle of DRAIN with a sample held in the output register.
    done_cnt = 0;
    cyc(0, 0, '0, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++) wr(500 + k, 0);
    cyc(0, 0, '0, 0, 1, 0, 0);
    idle(1, 0);
    chk("t6_pre_valid", 32'(out_valid), 32'd1);
    cyc(1, 0, '0, 0, 0, 0, 0);
    chk("t6_valid_clr", 32'(out_valid), 32'd0);
    chk("t6_busy_clr", 32'(busy), 32'd0);
    chk("t6_occ_clr", 32'(occupancy), 32'd0);
    got_q.delete();
    for (int k = 0; k < 4; k++) wr(600 + k, 1);
    cyc(0, 0, '0, 1, 0, 10, 1);
    idle(6, 1);
    want_q = '{16'd600, 16'd601, 16'd602, 16'd603};
    check_got("t6_replay");
    chk("t6_no_done", 32'(done_cnt), 32'd0);
    cyc(0, 0, '0, 0, 1, 0, 1);
    idle(3, 1);

    // Randomized traffic with varying backpressure.
    rdy_bias = 7;
    for (int c = 0; c < 3000; c++) begin
      if (c % 100 == 0) rdy_bias = $urandom_range(0, 10);
      r   = ($urandom_range(0, 399) == 0);
      iv  = $urandom_range(0, 1) == 1;
      trg = ($urandom_range(0, 29) == 0);
      ge  = ($urandom_range(0, 29) == 0);
      rdy = ($urandom_range(0, 9) < rdy_bias);
      cyc(r, iv, DW'($urandom), trg, ge, $urandom_range(0, 31), rdy);
    end

    // Close any open capture and let everything drain.
    cyc(0, 0, '0, 0, 1, 0, 1);
    idle(40, 1);
    chk("final_busy", 32'(busy), 32'd0);
    chk("final_scoreboard_left", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
